// File: rtl/router_fsm.sv
// ============================================================================
//  Module      : router_fsm
//  Description : Packet-control FSM of the 1x3 router. Decodes the header
//                address and sequences header, payload and parity bytes into
//                the selected FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module router_fsm #(
    parameter logic [1:0] INVALID_ADDR = 2'd3,
    parameter int         STATE_W      = 3
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       pkt_valid,
    input  logic [1:0] data_in,
    input  logic       parity_done,
    input  logic       low_pkt_valid,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       soft_reset_0,
    input  logic       soft_reset_1,
    input  logic       soft_reset_2,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       write_enb_reg,
    output logic       rst_int_reg
);

    typedef enum logic [STATE_W-1:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [1:0] sel_addr;
    logic       sel_empty;
    logic       sel_soft;
    logic       hdr_ok;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // While decoding, the header on data_in picks the FIFO; afterwards the latched address does.
    always_comb begin
        sel_addr = (state_q == DECODE_ADDRESS) ? data_in : addr_q;
        case (sel_addr)
            2'd0:    sel_empty = fifo_empty_0;
            2'd1:    sel_empty = fifo_empty_1;
            2'd2:    sel_empty = fifo_empty_2;
            default: sel_empty = 1'b0;
        endcase
        case (addr_q)
            2'd0:    sel_soft = soft_reset_0;
            2'd1:    sel_soft = soft_reset_1;
            2'd2:    sel_soft = soft_reset_2;
            default: sel_soft = 1'b0;
        endcase
    end

    assign hdr_ok = pkt_valid && (data_in != INVALID_ADDR);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (hdr_ok) begin
                    addr_d  = data_in;
                    state_d = sel_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                end
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY: begin
                if (sel_empty) state_d = LOAD_FIRST_DATA;
            end
            default: state_d = DECODE_ADDRESS;
        endcase
        // A timeout on the FIFO being served aborts the packet from any state.
        if (sel_soft) state_d = DECODE_ADDRESS;
    end

    always_comb begin
        busy          = 1'b1;
        detect_add    = 1'b0;
        lfd_state     = 1'b0;
        ld_state      = 1'b0;
        laf_state     = 1'b0;
        full_state    = 1'b0;
        write_enb_reg = 1'b0;
        rst_int_reg   = 1'b0;
        case (state_q)
            DECODE_ADDRESS: begin
                busy       = 1'b0;
                detect_add = 1'b1;
            end
            LOAD_FIRST_DATA: lfd_state = 1'b1;
            LOAD_DATA: begin
                busy          = 1'b0;
                ld_state      = 1'b1;
                write_enb_reg = 1'b1;
            end
            FIFO_FULL_STATE: full_state = 1'b1;
            LOAD_AFTER_FULL: begin
                laf_state     = 1'b1;
                write_enb_reg = 1'b1;
            end
            LOAD_PARITY:        write_enb_reg = 1'b1;
            CHECK_PARITY_ERROR: rst_int_reg   = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_router_fsm.sv
// ============================================================================
//  Module      : tb_router_fsm
//  Description : Directed self-checking bench for router_fsm.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_router_fsm;

    logic       clock = 1'b0;
    logic       resetn;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic       parity_done, low_pkt_valid, fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;
    logic       busy, detect_add, lfd_state, ld_state, laf_state;
    logic       full_state, write_enb_reg, rst_int_reg;

    int errors = 0;
    int checks = 0;

    // {busy, detect_add, lfd, ld, laf, full, wr_en, rst_int} expected per state
    localparam logic [7:0] E_DA  = 8'b0100_0000;
    localparam logic [7:0] E_LFD = 8'b1010_0000;
    localparam logic [7:0] E_LD  = 8'b0001_0010;
    localparam logic [7:0] E_FUL = 8'b1000_0100;
    localparam logic [7:0] E_LAF = 8'b1000_1010;
    localparam logic [7:0] E_LP  = 8'b1000_0010;
    localparam logic [7:0] E_CPE = 8'b1000_0001;
    localparam logic [7:0] E_WTE = 8'b1000_0000;

    router_fsm dut (
        .clock         (clock),
        .resetn        (resetn),
        .pkt_valid     (pkt_valid),
        .data_in       (data_in),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fifo_empty_0),
        .fifo_empty_1  (fifo_empty_1),
        .fifo_empty_2  (fifo_empty_2),
        .soft_reset_0  (soft_reset_0),
        .soft_reset_1  (soft_reset_1),
        .soft_reset_2  (soft_reset_2),
        .busy          (busy),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        obs = {busy, detect_add, lfd_state, ld_state, laf_state,
               full_state, write_enb_reg, rst_int_reg};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(input string tag, input logic [1:0] exp);
        checks++;
        assert (dut.addr_q === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, dut.addr_q, exp);
        end
    endtask

    initial begin
        resetn = 1'b0; pkt_valid = 1'b0; data_in = 2'd0;
        parity_done = 1'b0; low_pkt_valid = 1'b0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b0; soft_reset_2 = 1'b0;
        #1;
        chk("reset_outputs", E_DA);
        chk_addr("reset_addr", 2'd0);
        tick();
        resetn = 1'b1;
        tick();
        chk("idle", E_DA);

        // Full packet to FIFO 1: header 8'h39 then 14 payload bytes, then parity
        pkt_valid = 1'b1; data_in = 2'b01;
        tick();
        chk("t2_lfd", E_LFD);
        chk_addr("t2_addr", 2'd1);
        data_in = 2'b10;
        tick();
        for (int i = 0; i < 13; i++) begin
            chk("t2_ld", E_LD);
            tick();
        end
        pkt_valid = 1'b0;
        chk("t2_ld_last", E_LD);
        tick();
        chk("t2_parity", E_LP);
        tick();
        chk("t2_chk_parity", E_CPE);
        tick();
        chk("t2_done", E_DA);

        // Asynchronous reset in the middle of LOAD_DATA
        pkt_valid = 1'b1; data_in = 2'd0;
        tick();
        tick();
        chk("t1_in_ld", E_LD);
        #2 resetn = 1'b0;
        #1;
        chk("t1_async_reset", E_DA);
        chk_addr("t1_addr_cleared", 2'd0);
        pkt_valid = 1'b0;
        tick();
        resetn = 1'b1;
        tick();

        // Destination FIFO 2 not empty: wait, then go once it drains
        fifo_empty_2 = 1'b0; pkt_valid = 1'b1; data_in = 2'd2;
        tick();
        data_in = 2'd0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_wait", E_WTE);
            tick();
        end
        fifo_empty_2 = 1'b1;
        chk("t3_wait_moore", E_WTE);
        tick();
        chk("t3_lfd", E_LFD);
        tick();
        chk("t3_ld", E_LD);
        pkt_valid = 1'b0;
        tick();
        chk("t3_parity", E_LP);
        tick();
        tick();
        chk("t3_done", E_DA);

        // FIFO full at the 3rd payload byte
        pkt_valid = 1'b1; data_in = 2'd0;
        tick();
        tick();
        tick();
        chk("t4_ld3", E_LD);
        fifo_full = 1'b1;
        tick();
        chk("t4_full", E_FUL);
        tick();
        chk("t4_full_hold", E_FUL);
        fifo_full = 1'b0;
        tick();
        chk("t4_laf", E_LAF);
        tick();
        chk("t4_laf_to_ld", E_LD);
        fifo_full = 1'b1; pkt_valid = 1'b0;
        tick();
        chk("t4_full_priority", E_FUL);
        fifo_full = 1'b0;
        tick();
        chk("t4_laf2", E_LAF);
        low_pkt_valid = 1'b1;
        tick();
        chk("t4_laf_to_lp", E_LP);
        low_pkt_valid = 1'b0;
        tick();
        chk("t4_cpe", E_CPE);
        fifo_full = 1'b1;
        tick();
        chk("t4_cpe_to_full", E_FUL);
        fifo_full = 1'b0;
        tick();
        chk("t4_laf3", E_LAF);
        parity_done = 1'b1;
        tick();
        chk("t4_laf_to_da", E_DA);
        parity_done = 1'b0;

        // Soft reset while waiting on FIFO 1
        fifo_empty_1 = 1'b0; pkt_valid = 1'b1; data_in = 2'd1;
        tick();
        chk("t5_wait", E_WTE);
        soft_reset_0 = 1'b1;
        tick();
        chk("t5_other_soft_ignored", E_WTE);
        soft_reset_0 = 1'b0; soft_reset_1 = 1'b1; fifo_empty_1 = 1'b1;
        tick();
        chk("t5_soft_abort", E_DA);
        soft_reset_1 = 1'b0; pkt_valid = 1'b0;
        tick();

        // Invalid address 3 is never accepted
        chk_addr("t6_addr_before", 2'd1);
        pkt_valid = 1'b1; data_in = 2'd3;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_stay_decode", E_DA);
        end
        chk_addr("t6_addr_kept", 2'd1);
        pkt_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
